// File: rtl/uart_cmd_controller_if.sv
// Handshake bundle between the command controller and its UART RX/TX and register file.
// The controller uses the master modport; the surrounding logic uses slave.
interface uart_cmd_controller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_valid;
    logic [ADDR_WIDTH-1:0] o_rf_addr;
    logic [DATA_WIDTH-1:0] o_rf_wr_data;
    logic                  o_rf_wr_en;
    logic                  o_rf_rd_en;
    logic [DATA_WIDTH-1:0] i_rf_rd_data;
    logic                  i_rf_rd_valid;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_busy;
    logic                  o_cmd_error;

    modport master (
        input  i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid, i_tx_busy,
        output o_rf_addr, o_rf_wr_data, o_rf_wr_en, o_rf_rd_en,
               o_tx_data, o_tx_valid, o_cmd_error
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid, i_tx_busy,
        input  o_rf_addr, o_rf_wr_data, o_rf_wr_en, o_rf_rd_en,
               o_tx_data, o_tx_valid, o_cmd_error
    );
endinterface

// File: rtl/uart_cmd_controller.sv
// Parses UART byte frames into register-file writes/reads and returns read data to UART TX.
//   state   | meaning
//   IDLE    | waiting for an opcode byte
//   WR_ADDR | write frame, waiting for address byte
//   WR_DATA | write frame, waiting for data byte
//   RD_ADDR | read frame, waiting for address byte
//   RD_WAIT | read strobe issued, waiting for register data
//   TX_SEND | holding read data on TX until the serializer takes it
module uart_cmd_controller #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDR_WIDTH    = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD        = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD        = 8'hBB,
    parameter int                    FRAME_TIMEOUT = 1023,
    parameter int                    RD_TIMEOUT    = 15
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    uart_cmd_controller_if.master  bus
);
    localparam int TMAX = (FRAME_TIMEOUT > RD_TIMEOUT) ? FRAME_TIMEOUT : RD_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] FRAME_TC = CW'(FRAME_TIMEOUT);
    localparam logic [CW-1:0] RD_TC    = CW'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.o_rf_addr    <= '0;
            bus.o_rf_wr_data <= '0;
            bus.o_rf_wr_en   <= 1'b0;
            bus.o_rf_rd_en   <= 1'b0;
            bus.o_tx_data    <= '0;
            bus.o_tx_valid   <= 1'b0;
            bus.o_cmd_error  <= 1'b0;
        end else begin
            bus.o_rf_wr_en  <= 1'b0;
            bus.o_rf_rd_en  <= 1'b0;
            bus.o_cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.i_rx_valid) begin
                        if (bus.i_rx_data == WR_CMD)      state <= WR_ADDR;
                        else if (bus.i_rx_data == RD_CMD) state <= RD_ADDR;
                        else                              bus.o_cmd_error <= 1'b1;
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    // Expiry takes priority over a byte arriving in the same cycle.
                    if (cnt == FRAME_TC) begin
                        bus.o_cmd_error <= 1'b1;
                        state           <= IDLE;
                        cnt             <= '0;
                    end else if (bus.i_rx_valid) begin
                        bus.o_rf_addr <= bus.i_rx_data[ADDR_WIDTH-1:0];
                        cnt           <= '0;
                        if (state == WR_ADDR) begin
                            state <= WR_DATA;
                        end else begin
                            bus.o_rf_rd_en <= 1'b1;
                            state          <= RD_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_DATA: begin
                    if (cnt == FRAME_TC) begin
                        bus.o_cmd_error <= 1'b1;
                        state           <= IDLE;
                        cnt             <= '0;
                    end else if (bus.i_rx_valid) begin
                        bus.o_rf_wr_data <= bus.i_rx_data;
                        bus.o_rf_wr_en   <= 1'b1;
                        state            <= IDLE;
                        cnt              <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (bus.i_rx_valid) bus.o_cmd_error <= 1'b1;
                    if (cnt == RD_TC) begin
                        bus.o_cmd_error <= 1'b1;
                        state           <= IDLE;
                        cnt             <= '0;
                    end else if (bus.i_rf_rd_valid) begin
                        bus.o_tx_data  <= bus.i_rf_rd_data;
                        bus.o_tx_valid <= 1'b1;
                        state          <= TX_SEND;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_SEND: begin
                    cnt <= '0;
                    if (bus.i_rx_valid) bus.o_cmd_error <= 1'b1;
                    if (!bus.i_tx_busy) begin
                        bus.o_tx_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed bench for uart_cmd_controller: frames, timeouts, TX backpressure and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_cmd_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int wr_pulses = 0, rd_pulses = 0, err_pulses = 0, xfers = 0, txv_cycles = 0;

    always #5 clk = ~clk;

    uart_cmd_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus();

    uart_cmd_controller dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.o_rf_wr_en)                     wr_pulses++;
            if (bus.o_rf_rd_en)                     rd_pulses++;
            if (bus.o_cmd_error)                    err_pulses++;
            if (bus.o_tx_valid)                     txv_cycles++;
            if (bus.o_tx_valid && !bus.i_tx_busy)   xfers++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after the byte was captured.
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
    endtask

    task automatic test_reset();
        bus.i_rx_data = '0; bus.i_rx_valid = 0; bus.i_rf_rd_data = '0;
        bus.i_rf_rd_valid = 0; bus.i_tx_busy = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_rf_addr, bus.o_rf_wr_data, bus.o_rf_wr_en, bus.o_rf_rd_en,
             bus.o_tx_data, bus.o_tx_valid, bus.o_cmd_error} !== 31'd0) begin
            errors++; $display("FAIL reset_outputs: got nonzero/unknown outputs, expected all 0");
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_rf_wr_en, bus.o_rf_rd_en, bus.o_tx_valid, bus.o_cmd_error} !== 4'd0) begin
            errors++; $display("FAIL reset_release_idle: strobes %b expected 0000",
                {bus.o_rf_wr_en, bus.o_rf_rd_en, bus.o_tx_valid, bus.o_cmd_error});
        end
    endtask

    task automatic test_write();
        int e0 = err_pulses;
        int w0 = wr_pulses;
        send_byte(8'hAA);
        send_byte(8'h05);
        checks++;
        if (bus.o_rf_wr_en !== 1'b0 || bus.o_rf_addr !== 4'h5) begin
            errors++; $display("FAIL write_addr_phase: wr_en=%b addr=%h expected wr_en=0 addr=5",
                bus.o_rf_wr_en, bus.o_rf_addr);
        end
        send_byte(8'h3C);
        checks++;
        if (bus.o_rf_wr_en !== 1'b1 || bus.o_rf_addr !== 4'h5 || bus.o_rf_wr_data !== 8'h3C) begin
            errors++; $display("FAIL write_strobe: wr_en=%b addr=%h data=%h expected 1/5/3c",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
        end
        @(negedge clk);
        checks++;
        if (bus.o_rf_wr_en !== 1'b0 || wr_pulses - w0 != 1 || err_pulses != e0) begin
            errors++; $display("FAIL write_single: wr_en=%b pulses=%0d errs=%0d expected 0/1/0",
                bus.o_rf_wr_en, wr_pulses - w0, err_pulses - e0);
        end
    endtask

    task automatic test_read();
        int x0 = xfers;
        int e0;
        int held_bad = 0;
        bus.i_tx_busy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h0A);
        checks++;
        if (bus.o_rf_rd_en !== 1'b1 || bus.o_rf_addr !== 4'hA) begin
            errors++; $display("FAIL read_strobe: rd_en=%b addr=%h expected 1/a",
                bus.o_rf_rd_en, bus.o_rf_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.o_rf_rd_en !== 1'b0 || bus.o_tx_valid !== 1'b0) begin
            errors++; $display("FAIL read_strobe_single: rd_en=%b tx_valid=%b expected 0/0",
                bus.o_rf_rd_en, bus.o_tx_valid);
        end
        @(negedge clk);
        bus.i_rf_rd_data = 8'h77; bus.i_rf_rd_valid = 1'b1;
        @(negedge clk);
        bus.i_rf_rd_valid = 1'b0; bus.i_rf_rd_data = 8'h00;
        checks++;
        if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== 8'h77) begin
            errors++; $display("FAIL read_tx_latency: tx_valid=%b data=%h expected 1/77",
                bus.o_tx_valid, bus.o_tx_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== 8'h77) held_bad++;
        end
        e0 = err_pulses;
        send_byte(8'h12);
        checks++;
        if (bus.o_cmd_error !== 1'b1 || bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== 8'h77) begin
            errors++; $display("FAIL tx_send_extra_byte: err=%b tx_valid=%b data=%h expected 1/1/77",
                bus.o_cmd_error, bus.o_tx_valid, bus.o_tx_data);
        end
        bus.i_rf_rd_data = 8'h99; bus.i_rf_rd_valid = 1'b1;
        @(negedge clk);
        bus.i_rf_rd_valid = 1'b0; bus.i_rf_rd_data = 8'h00;
        checks++;
        if (bus.o_cmd_error !== 1'b0 || err_pulses - e0 != 1 || bus.o_tx_data !== 8'h77) begin
            errors++; $display("FAIL tx_send_ignore: err=%b errs=%0d data=%h expected 0/1/77",
                bus.o_cmd_error, err_pulses - e0, bus.o_tx_data);
        end
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== 8'h77) held_bad++;
        end
        checks++;
        if (held_bad != 0 || xfers != x0) begin
            errors++; $display("FAIL tx_hold_busy: bad_cycles=%0d xfers=%0d expected 0/0",
                held_bad, xfers - x0);
        end
        bus.i_tx_busy = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.o_tx_valid !== 1'b0 || xfers - x0 != 1) begin
            errors++; $display("FAIL tx_single_transfer: tx_valid=%b xfers=%0d expected 0/1",
                bus.o_tx_valid, xfers - x0);
        end
    endtask

    task automatic test_bad_opcode();
        int e0 = err_pulses;
        int w0 = wr_pulses;
        send_byte(8'h55);
        checks++;
        if (bus.o_cmd_error !== 1'b1) begin
            errors++; $display("FAIL bad_opcode_err: got %b expected 1", bus.o_cmd_error);
        end
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h11);
        checks++;
        if (bus.o_rf_wr_en !== 1'b1 || bus.o_rf_addr !== 4'h3 || bus.o_rf_wr_data !== 8'h11
            || err_pulses - e0 != 1 || wr_pulses != w0) begin
            errors++; $display("FAIL bad_opcode_recover: wr_en=%b addr=%h data=%h errs=%0d expected 1/3/11/1",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data, err_pulses - e0);
        end
        @(negedge clk);
    endtask

    task automatic test_frame_timeout();
        int w0 = wr_pulses;
        int k = 0;
        send_byte(8'hAA);
        for (k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (bus.o_cmd_error === 1'b1) break;
        end
        checks++;
        if (k != 1024 || wr_pulses != w0) begin
            errors++; $display("FAIL frame_timeout: err at cycle %0d wr=%0d expected 1024/0",
                k, wr_pulses - w0);
        end
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h22);
        checks++;
        if (bus.o_rf_wr_en !== 1'b1 || bus.o_rf_addr !== 4'h1 || bus.o_rf_wr_data !== 8'h22) begin
            errors++; $display("FAIL frame_timeout_recover: wr_en=%b addr=%h data=%h expected 1/1/22",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_collision();
        int e0;
        send_byte(8'hAA);
        repeat (1023) @(negedge clk);
        e0 = err_pulses;
        send_byte(8'h05);
        checks++;
        if (bus.o_cmd_error !== 1'b1) begin
            errors++; $display("FAIL collision_err: got %b expected 1", bus.o_cmd_error);
        end
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'h44);
        checks++;
        if (bus.o_rf_wr_en !== 1'b1 || bus.o_rf_addr !== 4'h7 || bus.o_rf_wr_data !== 8'h44
            || err_pulses - e0 != 1) begin
            errors++; $display("FAIL collision_drop: wr_en=%b addr=%h data=%h errs=%0d expected 1/7/44/1",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data, err_pulses - e0);
        end
        @(negedge clk);
    endtask

    task automatic test_read_timeout();
        int t0 = txv_cycles;
        int k = 0;
        send_byte(8'hBB);
        send_byte(8'h02);
        checks++;
        if (bus.o_rf_rd_en !== 1'b1 || bus.o_rf_addr !== 4'h2) begin
            errors++; $display("FAIL rd_timeout_strobe: rd_en=%b addr=%h expected 1/2",
                bus.o_rf_rd_en, bus.o_rf_addr);
        end
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.o_cmd_error === 1'b1) break;
        end
        checks++;
        if (k != 16) begin
            errors++; $display("FAIL rd_timeout_cycle: err at cycle %0d expected 16", k);
        end
        bus.i_rf_rd_data = 8'h66; bus.i_rf_rd_valid = 1'b1;
        @(negedge clk);
        bus.i_rf_rd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (txv_cycles != t0 || bus.o_tx_data === 8'h66) begin
            errors++; $display("FAIL rd_timeout_no_tx: tx_valid cycles=%0d data=%h expected 0/not 66",
                txv_cycles - t0, bus.o_tx_data);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_rf_wr_en !== 1'b0 || bus.o_rf_addr !== 4'h0 || bus.o_rf_wr_data !== 8'h00) begin
            errors++; $display("FAIL reset_pending_strobe: wr_en=%b addr=%h data=%h expected 0/0/0",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hAA);
        send_byte(8'h09);
        w0 = wr_pulses;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_rf_addr, bus.o_rf_wr_data, bus.o_rf_wr_en, bus.o_rf_rd_en,
             bus.o_tx_data, bus.o_tx_valid, bus.o_cmd_error} !== 31'd0) begin
            errors++; $display("FAIL reset_mid_frame: addr=%h expected all outputs 0", bus.o_rf_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h3C);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_pulses != w0) begin
            errors++; $display("FAIL reset_no_write: writes=%0d expected 0", wr_pulses - w0);
        end
        send_byte(8'hAA);
        send_byte(8'h0F);
        send_byte(8'hFF);
        checks++;
        if (bus.o_rf_wr_en !== 1'b1 || bus.o_rf_addr !== 4'hF || bus.o_rf_wr_data !== 8'hFF) begin
            errors++; $display("FAIL reset_recover_write: wr_en=%b addr=%h data=%h expected 1/f/ff",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int e0 = err_pulses;
        int x0 = xfers;
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h5A);
        checks++;
        if (bus.o_rf_wr_en !== 1'b1 || bus.o_rf_addr !== 4'h2 || bus.o_rf_wr_data !== 8'h5A) begin
            errors++; $display("FAIL b2b_first: wr_en=%b addr=%h data=%h expected 1/2/5a",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
        end
        send_byte(8'hAA);
        send_byte(8'h0E);
        send_byte(8'hC3);
        checks++;
        if (bus.o_rf_wr_en !== 1'b1 || bus.o_rf_addr !== 4'hE || bus.o_rf_wr_data !== 8'hC3) begin
            errors++; $display("FAIL b2b_second: wr_en=%b addr=%h data=%h expected 1/e/c3",
                bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
        end
        send_byte(8'hBB);
        send_byte(8'h04);
        bus.i_rf_rd_data = 8'h3D; bus.i_rf_rd_valid = 1'b1;
        @(negedge clk);
        bus.i_rf_rd_valid = 1'b0; bus.i_rf_rd_data = 8'h00;
        checks++;
        if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== 8'h3D || err_pulses != e0) begin
            errors++; $display("FAIL b2b_read_same_cycle: tx_valid=%b data=%h errs=%0d expected 1/3d/0",
                bus.o_tx_valid, bus.o_tx_data, err_pulses - e0);
        end
        @(negedge clk);
        checks++;
        if (bus.o_tx_valid !== 1'b0 || xfers - x0 != 1) begin
            errors++; $display("FAIL b2b_tx_done: tx_valid=%b xfers=%0d expected 0/1",
                bus.o_tx_valid, xfers - x0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_frame_timeout();
        test_timeout_collision();
        test_read_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
